// File: rtl/pipeline_mem_stage.sv
// MEM stage of the 5-stage pipe: drives the data-memory req/gnt/rvalid bus, aligns load data,
// picks the write-back value and registers it into the MEM/WB boundary.
module pipeline_mem_stage #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_e_i,
  input  logic [31:0] rs2_e_i,
  input  logic [3:0]  dmem_type_e_i,
  input  logic [31:0] extended_imm_e_i,
  input  logic [31:0] pc_plus4_e_i,
  input  logic        reg_write_en_e_i,
  input  logic [4:0]  rd_idx_e_i,
  input  logic [4:0]  result_src_e_i,
  input  logic        instr_illegal_e_i,
  input  logic [31:0] CSR_data_e_i,
  input  logic        flush_m_i,
  input  logic        st_m_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        busy_m_o,
  output logic [31:0] bypass_m_o,
  output logic [31:0] result_m_o,
  output logic        reg_write_en_m_o,
  output logic [4:0]  rd_idx_m_o,
  output logic        instr_illegal_m_o,
  output logic        misaligned_m_o,
  output logic        bus_err_m_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [3:0] T_LB = 4'b0001, T_LH = 4'b0010, T_LW = 4'b0011, T_LBU = 4'b0100,
                         T_LHU = 4'b0101, T_SB = 4'b1000, T_SH = 4'b1001, T_SW = 4'b1010;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d, type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d, kill_q, kill_d;
  logic [31:0] result_q, result_d;
  logic        rwe_q, rwe_d, ill_q, ill_d, mis_q, mis_d, berr_q, berr_d;
  logic [4:0]  rd_q, rd_d;

  logic        is_load, is_store, sz_b, sz_h, sz_w, mis, go;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_ext;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        load_done, timeout, busy, kill, upd;

  assign off = alu_result_e_i[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_b     = 1'b0;
    sz_h     = 1'b0;
    sz_w     = 1'b0;
    case (dmem_type_e_i)
      T_LB, T_LBU: begin is_load = 1'b1;  sz_b = 1'b1; end
      T_LH, T_LHU: begin is_load = 1'b1;  sz_h = 1'b1; end
      T_LW:        begin is_load = 1'b1;  sz_w = 1'b1; end
      T_SB:        begin is_store = 1'b1; sz_b = 1'b1; end
      T_SH:        begin is_store = 1'b1; sz_h = 1'b1; end
      T_SW:        begin is_store = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
    mis = (is_load | is_store) & ((sz_h & off[0]) | (sz_w & (off != 2'b00)));
    go  = (state_q == IDLE) & (is_load | is_store) & ~mis & ~flush_m_i;
    be_c    = sz_w ? 4'b1111 : sz_h ? (4'b0011 << {off[1], 1'b0}) : (4'b0001 << off);
    wdata_c = sz_w ? rs2_e_i : sz_h ? {2{rs2_e_i[15:0]}} : {4{rs2_e_i[7:0]}};
  end

  // Extraction uses the type/offset captured at issue, not the (possibly changing) EXE inputs.
  always_comb begin
    case (off_q)
      2'd0:    lb = dmem_rdata_i[7:0];
      2'd1:    lb = dmem_rdata_i[15:8];
      2'd2:    lb = dmem_rdata_i[23:16];
      default: lb = dmem_rdata_i[31:24];
    endcase
    lh = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (type_q)
      T_LB:    load_ext = {{24{lb[7]}}, lb};
      T_LBU:   load_ext = {24'd0, lb};
      T_LH:    load_ext = {{16{lh[15]}}, lh};
      T_LHU:   load_ext = {16'd0, lh};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    type_d    = type_q;
    off_d     = off_q;
    we_d      = we_q;
    kill_d    = kill_q;
    load_done = 1'b0;
    timeout   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (go) begin
          addr_d  = {alu_result_e_i[31:2], 2'b00};
          wdata_d = wdata_c;
          be_d    = be_c;
          type_d  = dmem_type_e_i;
          off_d   = off;
          we_d    = is_store;
          cnt_d   = 8'd0;
          busy    = is_load | ~dmem_gnt_i;
          if (dmem_gnt_i) state_d = is_load ? RESP : IDLE;
          else            state_d = REQ;
        end
      end
      REQ: begin
        kill_d = kill_q | flush_m_i;
        cnt_d  = 8'd0;
        busy   = ~we_q | ~dmem_gnt_i;
        if (dmem_gnt_i) state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        kill_d = kill_q | flush_m_i;
        if (dmem_rvalid_i) begin
          state_d   = IDLE;
          load_done = 1'b1;
        end else if (cnt_q == 8'(RESP_TIMEOUT)) begin
          state_d = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          busy  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kill = flush_m_i | ((state_q != IDLE) & kill_q);
  assign upd  = ~busy & ~st_m_i;

  always_comb begin
    bypass_m_o = ({32{result_src_e_i[0]}} & alu_result_e_i)
               | ({32{result_src_e_i[1]}} & extended_imm_e_i)
               | ({32{result_src_e_i[3]}} & pc_plus4_e_i)
               | ({32{result_src_e_i[4]}} & CSR_data_e_i);
    result_d = result_q;
    rwe_d    = rwe_q;
    rd_d     = rd_q;
    ill_d    = ill_q;
    mis_d    = mis_q;
    berr_d   = berr_q;
    if (upd) begin
      result_d = bypass_m_o | ({32{result_src_e_i[2] & load_done}} & load_ext);
      rwe_d    = ~kill & reg_write_en_e_i & ~timeout & ~((state_q == IDLE) & mis);
      rd_d     = kill ? 5'd0 : rd_idx_e_i;
      ill_d    = ~kill & instr_illegal_e_i;
      mis_d    = ~kill & (state_q == IDLE) & mis;
      berr_d   = ~kill & timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      type_q   <= 4'd0;
      off_q    <= 2'd0;
      we_q     <= 1'b0;
      kill_q   <= 1'b0;
      result_q <= 32'd0;
      rwe_q    <= 1'b0;
      rd_q     <= 5'd0;
      ill_q    <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      type_q   <= type_d;
      off_q    <= off_d;
      we_q     <= we_d;
      kill_q   <= kill_d;
      result_q <= result_d;
      rwe_q    <= rwe_d;
      rd_q     <= rd_d;
      ill_q    <= ill_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  // Request is combinational from IDLE so a granted access costs no extra cycle.
  assign dmem_req_o   = ~reset & (go | (state_q == REQ));
  assign dmem_we_o    = (state_q == IDLE) ? is_store : we_q;
  assign dmem_addr_o  = (state_q == IDLE) ? {alu_result_e_i[31:2], 2'b00} : addr_q;
  assign dmem_be_o    = (state_q == IDLE) ? be_c : be_q;
  assign dmem_wdata_o = (state_q == IDLE) ? wdata_c : wdata_q;

  assign busy_m_o          = busy;
  assign result_m_o        = result_q;
  assign reg_write_en_m_o  = rwe_q;
  assign rd_idx_m_o        = rd_q;
  assign instr_illegal_m_o = ill_q;
  assign misaligned_m_o    = mis_q;
  assign bus_err_m_o       = berr_q;
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: loads, stores, misalignment, bypass, flush, timeout, reset.
module tb_pipeline_mem_stage;
  logic        clk = 1'b0, reset;
  logic [31:0] alu, rs2, imm, pc4, csr, rdata;
  logic [3:0]  dtype;
  logic        rwe_e, ill_e, flush, st, gnt, rvalid;
  logic [4:0]  rd_e, src;
  logic        req, we, busy, rwe_m, ill_m, mis_m, berr_m;
  logic [31:0] addr, wdata, bypass, result;
  logic [3:0]  be;
  logic [4:0]  rd_m;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  pipeline_mem_stage #(.RESP_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .alu_result_e_i(alu), .rs2_e_i(rs2), .dmem_type_e_i(dtype),
    .extended_imm_e_i(imm), .pc_plus4_e_i(pc4), .reg_write_en_e_i(rwe_e), .rd_idx_e_i(rd_e),
    .result_src_e_i(src), .instr_illegal_e_i(ill_e), .CSR_data_e_i(csr), .flush_m_i(flush),
    .st_m_i(st), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .busy_m_o(busy), .bypass_m_o(bypass), .result_m_o(result), .reg_write_en_m_o(rwe_m),
    .rd_idx_m_o(rd_m), .instr_illegal_m_o(ill_m), .misaligned_m_o(mis_m), .bus_err_m_o(berr_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    alu = 0; rs2 = 0; imm = 0; pc4 = 0; csr = 0; dtype = 0; rwe_e = 0; ill_e = 0;
    rd_e = 0; src = 0; flush = 0; st = 0; gnt = 0; rvalid = 0; rdata = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Load with same-cycle grant, rvalid three cycles after the request cycle.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [3:0] t,
                         input logic [31:0] rd, input logic [31:0] exp);
    int nb = 0;
    alu = a; dtype = t; src = 5'b00100; rwe_e = 1; rd_e = 5'd7; gnt = 1;
    @(negedge clk);
    chk({tag, "_req"}, {31'd0, req}, 1);
    chk({tag, "_addr"}, addr, {a[31:2], 2'b00});
    if (busy) nb++;
    nxt(); gnt = 0;
    repeat (2) begin
      @(negedge clk); if (busy) nb++;
      nxt();
    end
    rvalid = 1; rdata = rd;
    @(negedge clk); if (busy) nb++;
    nxt(); idle_in();
    chk({tag, "_busycyc"}, nb, 3);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_rwe"}, {31'd0, rwe_m}, 1);
    chk({tag, "_rd"}, {27'd0, rd_m}, 7);
  endtask

  initial begin
    int n;
    idle_in();
    reset = 1;
    repeat (3) nxt();
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {28'd0, rwe_m, mis_m, berr_m, ill_m}, 0);
    nxt(); reset = 0;

    do_load("lw", 32'h100, 4'b0011, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb", 32'h103, 4'b0001, 32'h80112233, 32'hFFFFFF80);
    do_load("lbu", 32'h103, 4'b0100, 32'h80112233, 32'h00000080);
    do_load("lh", 32'h102, 4'b0010, 32'h80112233, 32'hFFFF8011);
    do_load("lhu", 32'h100, 4'b0101, 32'h8011A233, 32'h0000A233);

    // SH with grant delayed three cycles; EXE inputs perturbed to show the request is held.
    alu = 32'h102; rs2 = 32'h0000ABCD; dtype = 4'b1001; rwe_e = 0; rd_e = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sh_req", {31'd0, req}, 1);
      chk("sh_we", {31'd0, we}, 1);
      chk("sh_be", {28'd0, be}, 4'b1100);
      chk("sh_wdata", wdata, 32'hABCDABCD);
      chk("sh_addr", addr, 32'h100);
      chk("sh_busy", {31'd0, busy}, 1);
      nxt(); alu = 32'h555; rs2 = 32'h12345678;
    end
    gnt = 1;
    @(negedge clk);
    chk("sh_gnt_busy", {31'd0, busy}, 0);
    nxt(); idle_in();
    chk("sh_rwe", {31'd0, rwe_m}, 0);
    @(negedge clk);
    chk("sh_req_done", {31'd0, req}, 0);

    // SB byte lane 1
    alu = 32'h201; rs2 = 32'h000000A5; dtype = 4'b1000; gnt = 1;
    @(negedge clk);
    chk("sb_be", {28'd0, be}, 4'b0010);
    chk("sb_wdata", wdata, 32'hA5A5A5A5);
    chk("sb_busy", {31'd0, busy}, 0);
    nxt(); idle_in();

    // Misaligned LW
    alu = 32'h101; dtype = 4'b0011; rwe_e = 1; rd_e = 5'd9; src = 5'b00100; gnt = 1;
    @(negedge clk);
    chk("mis_req", {31'd0, req}, 0);
    chk("mis_busy", {31'd0, busy}, 0);
    nxt(); idle_in();
    chk("mis_flag", {31'd0, mis_m}, 1);
    chk("mis_rwe", {31'd0, rwe_m}, 0);
    nxt();
    chk("mis_clear", {31'd0, mis_m}, 0);

    // pc+4 source: bypass same cycle, result next
    src = 5'b01000; pc4 = 32'h2004; alu = 32'h7777; rwe_e = 1; rd_e = 5'd1;
    @(negedge clk);
    chk("pc4_bypass", bypass, 32'h2004);
    chk("pc4_busy", {31'd0, busy}, 0);
    nxt(); idle_in();
    chk("pc4_result", result, 32'h2004);
    chk("pc4_rwe", {31'd0, rwe_m}, 1);

    // Load flushed while waiting for data: no write-back
    alu = 32'h300; dtype = 4'b0011; src = 5'b00100; rwe_e = 1; rd_e = 5'd4; gnt = 1;
    nxt(); gnt = 0; flush = 1;
    nxt(); flush = 0; rvalid = 1; rdata = 32'h11111111;
    nxt(); idle_in();
    chk("flush_rwe", {31'd0, rwe_m}, 0);
    chk("flush_rd", {27'd0, rd_m}, 0);

    // Timeout: granted LW never answered
    alu = 32'h400; dtype = 4'b0011; src = 5'b00100; rwe_e = 1; rd_e = 5'd2; gnt = 1;
    nxt(); gnt = 0;
    n = 0;
    while (berr_m !== 1'b1 && n < 400) begin
      nxt(); n++;
    end
    idle_in();
    chk("to_cycles", n, 256);
    chk("to_berr", {31'd0, berr_m}, 1);
    chk("to_rwe", {31'd0, rwe_m}, 0);
    @(negedge clk);
    chk("to_idle_busy", {31'd0, busy}, 0);

    // Reset mid-RESP, then a late rvalid must be ignored
    alu = 32'h500; dtype = 4'b0011; src = 5'b00100; rwe_e = 1; rd_e = 5'd6; gnt = 1;
    nxt(); idle_in(); reset = 1;
    nxt(); reset = 0;
    @(negedge clk);
    chk("rstm_req", {31'd0, req}, 0);
    chk("rstm_busy", {31'd0, busy}, 0);
    src = 5'b00100; rvalid = 1; rdata = 32'hFFFFFFFF;
    nxt(); idle_in();
    chk("rstm_result", result, 0);
    chk("rstm_berr", {31'd0, berr_m}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
